// File: rtl/ldpc_cn_scheduler_pkg.sv
// Shared types for the check-node scheduler: ALU request format, FSM states
// and min-sum constants.
package ldpc_cn_scheduler_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [3:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    MULT,
    CSR,
    FPU,
    FPU_VEC,
    CVXIF,
    ACCEL
  } fu_t;

  typedef enum logic [7:0] {
    ADD,
    SUB,
    ADDW,
    SUBW,
    XORL,
    ORL,
    ANDL,
    ANDN,
    ORN,
    XNOR,
    SRA,
    SRL,
    SLL,
    SRLW,
    SLLW,
    SRAW,
    LTS,
    LTU,
    GES,
    GEU,
    EQ,
    NE,
    JALR,
    BRANCH,
    SLTS,
    SLTU
  } fu_op;

  typedef struct packed {
    fu_t                      fu;
    fu_op                     operation;
    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          operand_b;
    logic [XLEN-1:0]          imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef enum logic [2:0] {
    CN_IDLE,
    CN_CMP1,
    CN_CMP2,
    CN_SCALE1,
    CN_SCALE2,
    CN_DONE
  } cn_state_e;

  // Largest positive message value; also the saturated magnitude of the most negative one.
  localparam logic [XLEN-1:0] LDPC_MAG_MAX = {1'b0, {(XLEN-1){1'b1}}};

endpackage

// File: rtl/ldpc_cn_scheduler_abs_sat.sv
// Saturating absolute value: the most negative input maps to the largest
// positive value instead of wrapping back to itself.
module ldpc_abs_sat
  import ldpc_cn_scheduler_pkg::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic [W-1:0] data_i,
  output logic [W-1:0] mag_o
);

  logic is_min_neg;

  assign is_min_neg = data_i[W-1] && (data_i[W-2:0] == '0);

  always_comb begin
    if (is_min_neg) begin
      mag_o = {1'b0, {(W-1){1'b1}}};
    end else if (data_i[W-1]) begin
      mag_o = -data_i;
    end else begin
      mag_o = data_i;
    end
  end

endmodule

// File: rtl/ldpc_cn_scheduler.sv
// Check-node min-sum engine sharing the core integer ALU; core requests always
// take the ALU and the engine simply stalls in place.
module ldpc_cn_scheduler
  import ldpc_cn_scheduler_pkg::*;
#(
  parameter int unsigned MAX_DEG = 32,
  parameter int unsigned IDX_W   = $clog2(MAX_DEG)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             core_valid_i,
  input  fu_data_t         core_fu_data_i,
  output fu_data_t         alu_fu_data_o,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic             alu_branch_res_i,
  input  logic             start_i,
  input  logic [IDX_W:0]   cfg_deg_i,
  input  logic             msg_valid_i,
  input  logic [XLEN-1:0]  msg_data_i,
  output logic             msg_ready_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [XLEN-1:0]  res_min1_o,
  output logic [XLEN-1:0]  res_min2_o,
  output logic [IDX_W-1:0] res_idx_o,
  output logic             res_sign_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam logic [IDX_W:0] DEG_MIN = (IDX_W+1)'(2);
  localparam logic [IDX_W:0] DEG_MAX = (IDX_W+1)'(MAX_DEG);

  cn_state_e        state_q;
  logic [IDX_W:0]   deg_q;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [XLEN-1:0]  min1_q;
  logic [XLEN-1:0]  min2_q;
  logic [XLEN-1:0]  mag_q;
  logic             sign_q;
  logic             err_q;
  logic [XLEN-1:0]  res_min1_q;
  logic [XLEN-1:0]  res_min2_q;
  logic [IDX_W-1:0] res_idx_q;
  logic             res_sign_q;

  logic             grant;
  logic             last;
  logic             deg_legal;
  logic             msg_hs;
  logic [XLEN-1:0]  mag_in;
  fu_data_t         eng_op;

  ldpc_abs_sat #(
    .W(XLEN)
  ) u_abs_sat (
    .data_i(msg_data_i),
    .mag_o (mag_in)
  );

  assign grant     = ~core_valid_i;
  assign last      = ({1'b0, cnt_q} == (deg_q - 1'b1));
  assign deg_legal = (cfg_deg_i >= DEG_MIN) && (cfg_deg_i <= DEG_MAX);
  assign msg_hs    = msg_ready_o && msg_valid_i;

  always_comb begin
    eng_op = '0;
    unique case (state_q)
      CN_CMP1: begin
        eng_op.fu        = ALU;
        eng_op.operation = LTS;
        eng_op.operand_a = mag_in;
        eng_op.operand_b = min1_q;
      end
      CN_CMP2: begin
        eng_op.fu        = ALU;
        eng_op.operation = LTS;
        eng_op.operand_a = mag_q;
        eng_op.operand_b = min2_q;
      end
      CN_SCALE1: begin
        eng_op.fu        = ALU;
        eng_op.operation = SUB;
        eng_op.operand_a = min1_q;
        eng_op.operand_b = XLEN'($signed(min1_q) >>> 2);
      end
      CN_SCALE2: begin
        eng_op.fu        = ALU;
        eng_op.operation = SUB;
        eng_op.operand_a = min2_q;
        eng_op.operand_b = XLEN'($signed(min2_q) >>> 2);
      end
      default: ;
    endcase
  end

  assign alu_fu_data_o = core_valid_i ? core_fu_data_i : eng_op;
  assign msg_ready_o   = (state_q == CN_CMP1) && grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CN_IDLE;
      deg_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      min1_q     <= '0;
      min2_q     <= '0;
      mag_q      <= '0;
      sign_q     <= 1'b0;
      err_q      <= 1'b0;
      res_min1_q <= '0;
      res_min2_q <= '0;
      res_idx_q  <= '0;
      res_sign_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        CN_IDLE: begin
          if (start_i) begin
            if (deg_legal) begin
              deg_q   <= cfg_deg_i;
              min1_q  <= LDPC_MAG_MAX;
              min2_q  <= LDPC_MAG_MAX;
              idx_q   <= '0;
              cnt_q   <= '0;
              sign_q  <= 1'b0;
              state_q <= CN_CMP1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        CN_CMP1: begin
          if (msg_hs) begin
            sign_q <= sign_q ^ msg_data_i[XLEN-1];
            mag_q  <= mag_in;
            // Strictly smaller only: ties defer to CMP2 so the first occurrence keeps idx.
            if (alu_branch_res_i) begin
              min2_q  <= min1_q;
              min1_q  <= mag_in;
              idx_q   <= cnt_q;
              cnt_q   <= cnt_q + 1'b1;
              state_q <= last ? CN_SCALE1 : CN_CMP1;
            end else begin
              state_q <= CN_CMP2;
            end
          end
        end
        CN_CMP2: begin
          if (grant) begin
            if (alu_branch_res_i) begin
              min2_q <= mag_q;
            end
            cnt_q   <= cnt_q + 1'b1;
            state_q <= last ? CN_SCALE1 : CN_CMP1;
          end
        end
        CN_SCALE1: begin
          if (grant) begin
            min1_q  <= alu_result_i;
            state_q <= CN_SCALE2;
          end
        end
        CN_SCALE2: begin
          if (grant) begin
            min2_q     <= alu_result_i;
            res_min1_q <= min1_q;
            res_min2_q <= alu_result_i;
            res_idx_q  <= idx_q;
            res_sign_q <= sign_q;
            state_q    <= CN_DONE;
          end
        end
        CN_DONE: begin
          if (res_ready_i) begin
            state_q <= CN_IDLE;
          end
        end
        default: state_q <= CN_IDLE;
      endcase
    end
  end

  assign res_valid_o = (state_q == CN_DONE);
  assign busy_o      = (state_q != CN_IDLE);
  assign err_o       = err_q;
  assign res_min1_o  = res_min1_q;
  assign res_min2_o  = res_min2_q;
  assign res_idx_o   = res_idx_q;
  assign res_sign_o  = res_sign_q;

endmodule

// File: tb/tb_ldpc_cn_scheduler.sv
// Bench for ldpc_cn_scheduler: behavioural ALU, directed vector table,
// hand-written error/reset sequences and randomized nodes against a min-sum model.
module tb_ldpc_cn_scheduler;
  import ldpc_cn_scheduler_pkg::*;

  localparam int unsigned MAXD = 32;
  localparam int unsigned IW   = 5;
  localparam logic [63:0] MINNEG = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAXPOS = 64'h7FFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          core_valid_i;
  fu_data_t      core_fu_data_i;
  fu_data_t      alu_fu_data_o;
  logic [63:0]   alu_result;
  logic          alu_branch;
  logic          start_i;
  logic [IW:0]   cfg_deg_i;
  logic          msg_valid_i;
  logic [63:0]   msg_data_i;
  logic          msg_ready_o;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [63:0]   res_min1_o;
  logic [63:0]   res_min2_o;
  logic [IW-1:0] res_idx_o;
  logic          res_sign_o;
  logic          busy_o;
  logic          err_o;

  always #5 clk = ~clk;

  ldpc_cn_scheduler #(
    .MAX_DEG(MAXD)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .core_valid_i    (core_valid_i),
    .core_fu_data_i  (core_fu_data_i),
    .alu_fu_data_o   (alu_fu_data_o),
    .alu_result_i    (alu_result),
    .alu_branch_res_i(alu_branch),
    .start_i         (start_i),
    .cfg_deg_i       (cfg_deg_i),
    .msg_valid_i     (msg_valid_i),
    .msg_data_i      (msg_data_i),
    .msg_ready_o     (msg_ready_o),
    .res_valid_o     (res_valid_o),
    .res_ready_i     (res_ready_i),
    .res_min1_o      (res_min1_o),
    .res_min2_o      (res_min2_o),
    .res_idx_o       (res_idx_o),
    .res_sign_o      (res_sign_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  // Behavioural integer ALU standing in for the shared functional unit.
  always_comb begin
    alu_result = '0;
    alu_branch = 1'b0;
    case (alu_fu_data_o.operation)
      ADD: alu_result = alu_fu_data_o.operand_a + alu_fu_data_o.operand_b;
      SUB: alu_result = alu_fu_data_o.operand_a - alu_fu_data_o.operand_b;
      LTS: begin
        alu_branch = $signed(alu_fu_data_o.operand_a) < $signed(alu_fu_data_o.operand_b);
        alu_result = {63'b0, alu_branch};
      end
      default: ;
    endcase
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [63:0] msgs [MAXD];

  typedef struct {
    int unsigned      deg;
    logic [3:0][63:0] m;
    int unsigned      s_lo;
    int unsigned      s_hi;
    logic [63:0]      e_min1;
    logic [63:0]      e_min2;
    int unsigned      e_idx;
    logic             e_sign;
    int unsigned      e_lat;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] s64(input int v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic fu_data_t rand_core();
    fu_data_t c;
    c.fu        = ALU;
    c.operation = ADD;
    c.operand_a = {$urandom, $urandom};
    c.operand_b = {$urandom, $urandom};
    c.imm       = {$urandom, $urandom};
    c.trans_id  = 3'($urandom);
    return c;
  endfunction

  function automatic logic [63:0] ref_mag(input logic [63:0] x);
    if (x == MINNEG) return MAXPOS;
    if ($signed(x) < 0) return 64'd0 - x;
    return x;
  endfunction

  // Drives one node from msgs[0..deg-1]; returns the cycle (after the start edge) where res_valid_o is seen, 0 on timeout.
  task automatic run_node(input int unsigned deg, input int unsigned s_lo, input int unsigned s_hi,
                          input int unsigned pct, output int unsigned lat);
    int unsigned k;
    k = 0;
    lat = 0;
    core_valid_i = 1'b0;
    msg_valid_i  = 1'b0;
    start_i      = 1'b1;
    cfg_deg_i    = (IW+1)'(deg);
    tick();
    start_i = 1'b0;
    for (int unsigned n = 1; n < 600; n++) begin
      core_valid_i   = ((n >= s_lo) && (n <= s_hi)) || ($urandom_range(99) < pct);
      core_fu_data_i = rand_core();
      msg_valid_i    = (k < deg) && ($urandom_range(99) >= pct);
      msg_data_i     = (k < deg) ? msgs[k] : '0;
      #1;
      if (res_valid_o) begin
        lat = n;
        break;
      end
      if (core_valid_i) begin
        chk("arb_core_wins", alu_fu_data_o == core_fu_data_i, 1'b1);
        chk("stall_ready_low", msg_ready_o, 1'b0);
      end
      if (msg_ready_o && msg_valid_i) k++;
      tick();
    end
    core_valid_i = 1'b0;
    msg_valid_i  = 1'b0;
  endtask

  task automatic apply(input string tag, input int unsigned deg, input int unsigned s_lo,
                       input int unsigned s_hi, input int unsigned pct,
                       input logic [63:0] e_min1, input logic [63:0] e_min2,
                       input int unsigned e_idx, input logic e_sign, input int unsigned e_lat);
    int unsigned lat;
    run_node(deg, s_lo, s_hi, pct, lat);
    if (e_lat != 0) chk({tag, "_latency"}, 64'(lat), 64'(e_lat));
    else chk({tag, "_done_seen"}, 64'(lat != 0), 64'd1);
    if (lat == 0) begin
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      return;
    end
    chk({tag, "_min1"}, res_min1_o, e_min1);
    chk({tag, "_min2"}, res_min2_o, e_min2);
    chk({tag, "_idx"}, 64'(res_idx_o), 64'(e_idx));
    chk({tag, "_sign"}, 64'(res_sign_o), 64'(e_sign));
    res_ready_i = 1'b0;
    tick();
    chk({tag, "_hold_valid"}, 64'(res_valid_o), 64'd1);
    chk({tag, "_hold_min2"}, res_min2_o, e_min2);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk({tag, "_idle_valid"}, 64'(res_valid_o), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_idle_min1"}, res_min1_o, e_min1);
  endtask

  task automatic apply_vec(input int unsigned i);
    for (int unsigned j = 0; j < tbl[i].deg; j++) msgs[j] = tbl[i].m[j];
    apply($sformatf("vec%0d", i), tbl[i].deg, tbl[i].s_lo, tbl[i].s_hi, 0,
          tbl[i].e_min1, tbl[i].e_min2, tbl[i].e_idx, tbl[i].e_sign, tbl[i].e_lat);
  endtask

  initial begin
    rst_i          = 1'b1;
    core_valid_i   = 1'b0;
    core_fu_data_i = '0;
    start_i        = 1'b0;
    cfg_deg_i      = '0;
    msg_valid_i    = 1'b0;
    msg_data_i     = '0;
    res_ready_i    = 1'b0;

    // deg 4 {5,-3,7,-9}, no stalls then with a 3-cycle stall over the first CMP2.
    tbl[0].deg = 4; tbl[0].s_lo = 0; tbl[0].s_hi = 0;
    tbl[0].m[0] = s64(5); tbl[0].m[1] = s64(-3); tbl[0].m[2] = s64(7); tbl[0].m[3] = s64(-9);
    tbl[0].e_min1 = 64'd3; tbl[0].e_min2 = 64'd4; tbl[0].e_idx = 1; tbl[0].e_sign = 1'b0; tbl[0].e_lat = 9;
    tbl[1] = tbl[0];
    tbl[1].s_lo = 4; tbl[1].s_hi = 6; tbl[1].e_lat = 12;
    tbl[2].deg = 3; tbl[2].s_lo = 0; tbl[2].s_hi = 0;
    tbl[2].m[0] = s64(4); tbl[2].m[1] = s64(4); tbl[2].m[2] = s64(-4); tbl[2].m[3] = '0;
    tbl[2].e_min1 = 64'd3; tbl[2].e_min2 = 64'd3; tbl[2].e_idx = 0; tbl[2].e_sign = 1'b1; tbl[2].e_lat = 8;
    tbl[3].deg = 2; tbl[3].s_lo = 0; tbl[3].s_hi = 0;
    tbl[3].m[0] = MINNEG; tbl[3].m[1] = s64(1); tbl[3].m[2] = '0; tbl[3].m[3] = '0;
    tbl[3].e_min1 = 64'd1; tbl[3].e_min2 = 64'h6000_0000_0000_0000; tbl[3].e_idx = 1;
    tbl[3].e_sign = 1'b1; tbl[3].e_lat = 6;
    tbl[4].deg = 2; tbl[4].s_lo = 0; tbl[4].s_hi = 0;
    tbl[4].m[0] = s64(2); tbl[4].m[1] = s64(-6); tbl[4].m[2] = '0; tbl[4].m[3] = '0;
    tbl[4].e_min1 = 64'd2; tbl[4].e_min2 = 64'd5; tbl[4].e_idx = 0; tbl[4].e_sign = 1'b1; tbl[4].e_lat = 6;

    tick();
    tick();
    chk("rst_res_valid", 64'(res_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_msg_ready", 64'(msg_ready_o), 64'd0);
    chk("rst_min1", res_min1_o, 64'd0);
    chk("rst_min2", res_min2_o, 64'd0);
    chk("rst_idx", 64'(res_idx_o), 64'd0);
    chk("rst_sign", 64'(res_sign_o), 64'd0);
    rst_i = 1'b0;
    tick();

    for (int unsigned i = 0; i < 4; i++) apply_vec(i);

    // Illegal degrees pulse err_o for one cycle; a start while busy is ignored.
    start_i = 1'b1; cfg_deg_i = 6'd1;
    tick();
    start_i = 1'b0;
    chk("err_deg1", 64'(err_o), 64'd1);
    chk("err_deg1_busy", 64'(busy_o), 64'd0);
    tick();
    chk("err_pulse_len", 64'(err_o), 64'd0);
    start_i = 1'b1; cfg_deg_i = 6'd33;
    tick();
    start_i = 1'b0;
    chk("err_deg33", 64'(err_o), 64'd1);
    tick();
    start_i = 1'b1; cfg_deg_i = 6'd4; msg_valid_i = 1'b0;
    tick();
    start_i = 1'b1; cfg_deg_i = 6'd1;
    tick();
    start_i = 1'b0;
    chk("cmp1_start_no_err", 64'(err_o), 64'd0);
    chk("cmp1_busy", 64'(busy_o), 64'd1);
    chk("cmp1_ready", 64'(msg_ready_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("abort_busy", 64'(busy_o), 64'd0);

    // Reset while in SCALE1: deg 2 {3,1} reaches SCALE1 two cycles after the start edge.
    start_i = 1'b1; cfg_deg_i = 6'd2;
    tick();
    start_i = 1'b0;
    msg_valid_i = 1'b1; msg_data_i = s64(3);
    tick();
    msg_data_i = s64(1);
    tick();
    msg_valid_i = 1'b0;
    chk("scale1_busy", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("scale1_rst_busy", 64'(busy_o), 64'd0);
    chk("scale1_rst_valid", 64'(res_valid_o), 64'd0);
    apply_vec(4);

    // Randomized nodes against the min-sum reference; latency checked only when unstalled.
    for (int unsigned t = 0; t < 40; t++) begin
      int unsigned deg, pct, e_idx, lat;
      logic [63:0] mags [MAXD];
      logic [63:0] m1, m2, run_min;
      logic        sgn;
      deg = (t % 8 == 0) ? MAXD : $urandom_range(MAXD, 2);
      pct = (t % 2 == 0) ? 0 : 30;
      for (int unsigned j = 0; j < deg; j++) begin
        case ($urandom_range(9))
          0:       msgs[j] = MINNEG;
          1:       msgs[j] = MAXPOS;
          2, 3:    msgs[j] = {$urandom, $urandom};
          default: msgs[j] = s64(int'($urandom_range(20)) - 10);
        endcase
        mags[j] = ref_mag(msgs[j]);
      end
      m1 = MAXPOS; e_idx = 0; sgn = 1'b0; lat = 3; run_min = MAXPOS;
      for (int unsigned j = 0; j < deg; j++) begin
        if (mags[j] < m1) begin
          m1 = mags[j];
          e_idx = j;
        end
        sgn = sgn ^ msgs[j][63];
        if (mags[j] < run_min) begin
          run_min = mags[j];
          lat += 1;
        end else begin
          lat += 2;
        end
      end
      m2 = MAXPOS;
      for (int unsigned j = 0; j < deg; j++) begin
        if ((j != e_idx) && (mags[j] < m2)) m2 = mags[j];
      end
      apply($sformatf("rnd%0d", t), deg, 0, 0, pct, m1 - m1 / 4, m2 - m2 / 4, e_idx, sgn,
            (pct == 0) ? lat : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
